halt_result_checker: RTL and testbench
======================================

# halt_result_checker

Synthesizable, parametrised on-chip self-test checker for the RISC machine. It watches the CPU's halt flag and PC, then reads back a programmable table of expected memory words through a spare synchronous read port and reports pass/fail on the board LEDs. It sits in the top level beside `CPU` and `MEM`. It generalises the halt-then-compare checks to N entries, adds a watchdog timeout and emits a failure code.

## Interface
Parameters:
- `AW`, 9: PC/address width.
- `DW`, 16: data width.
- `NCHK`, 4: number of expected-value entries (1..16).
- `TIMEOUT`, 1024: maximum RUN cycles before HALT is required.
- `HALT_PC`, 9'hF: required PC value while halted.
- `STUCK`, 64: PC-unchanged cycle limit (used only under `CHECKER_STUCK_PC_EN`).

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain).
- `reset_n`  in  1  reset (one clock; asynchronous, active-low).
- `start`  in  1  single-cycle pulse that arms a run.
- `halted`  in  1  CPU HALT indicator (drives LEDR[8]).
- `pc`  in  AW  CPU program counter.
- `cfg_we`  in  1  table write strobe.
- `cfg_idx`  in  $clog2(NCHK)  entry index.
- `cfg_addr`  in  AW  memory address to check.
- `cfg_data`  in  DW  expected word.
- `cfg_valid`  in  1  entry enable.
- `rd_en`  out  1  memory read request.
- `rd_addr`  out  AW  memory read address.
- `rd_data`  in  DW  read data, valid exactly 1 cycle after `rd_en`.
- `busy`  out  1  run or check in progress.
- `pass`  out  1  sticky pass.
- `fail`  out  1  sticky fail.
- `fail_code`  out  3  0 none, 1 timeout, 2 bad PC, 3 data mismatch, 4 stuck PC.
- `fail_idx`  out  $clog2(NCHK)  failing entry.
- `fail_got`  out  DW  word actually read on mismatch.

## Operation
- States:
  - IDLE: `start` → RUN; clears pass/fail/code/counters.
  - RUN: counter increments each cycle.
    - `halted`=1 → CHK_PC.
    - Counter reaches TIMEOUT-1 with `halted`=0 → FAIL, code 1.
    - If `halted` and the timeout coincide, `halted` wins.
  - CHK_PC: `pc`≠HALT_PC → FAIL, code 2. Otherwise set i=0 → SCAN.
  - SCAN: skip invalid entries (0 cycles each, via combinational next-valid search).
    - Valid entry i: assert `rd_en`, drive `rd_addr`=addr[i] → CMP.
    - No valid entry remaining → PASS.
  - CMP: `rd_data`≠data[i] → FAIL, code 3, `fail_idx`=i, `fail_got`=`rd_data`. Otherwise i+1 → SCAN.
  - PASS / FAIL: terminal. The result is held until `start` (→ RUN) or reset.
- Table writes (`cfg_we`) are accepted only in IDLE, PASS or FAIL. They are ignored while `busy`.
- `start` while `busy` is ignored.
- Comparisons are exact over DW bits. X/Z on `rd_data` counts as a mismatch.

## Timing
- Reset (async assert, synchronous release): state IDLE, all table valid bits 0, every output 0 (`rd_addr`=0).
- `busy`=1 from the cycle after `start` until the cycle PASS or FAIL is entered.
- `rd_en` is a single-cycle pulse per valid entry. It is never asserted outside SCAN.
- Latency from `halted` sampled high to `pass`: 1 (CHK_PC) + 2×(valid entries) + 1 cycles.
- Timeout fires on the TIMEOUT-th RUN cycle: `fail` asserts TIMEOUT+1 cycles after `start`.
- Reset asserted mid-run aborts immediately. Nothing is retained, including the table.

## Configuration
- `CHECKER_STUCK_PC_EN` defined:
  - A RUN-state counter reloads whenever `pc` changes.
  - If `pc` is unchanged for STUCK consecutive cycles with `halted`=0 → FAIL, code 4.
  - Priority order: halted > stuck > timeout.
- Undefined: no stuck counter is built. Code 4 is never produced. `STUCK` is unused.

## Structure
- Package `checker_pkg`:
  - State enum `chk_state_t`.
  - Fail-code enum `chk_fail_t` (NONE, TIMEOUT, BAD_PC, DATA, STUCK).
  - Packed struct `chk_entry_t` {valid, addr, data}.
- Sub-module `checker_entry_table`:
  - NCHK×`chk_entry_t` register array, one write port, one combinational read port.
  - Provides next-valid-index search from i.
  - Valid bits cleared on reset.

## Test plan
- Fig. 2 program, entry 0 = {0x14, 850}, `start` after reset → `pass`=1, `fail_code`=0, exactly one `rd_en` pulse, to address 0x14.
- Same program, entry 0 expects 851 → `fail`=1, code 3, `fail_idx`=0, `fail_got`=850.
- `halted` tied 0, TIMEOUT=200 → `fail` with code 1 exactly 201 cycles after `start`; `rd_en` never asserted.
- `halted`=1 with `pc`=0xE → `fail`, code 2, no reads issued.
- Entries 0, 2 valid, entries 1, 3 invalid, all matching → reads to addr[0] then addr[2] only; `pass` 6 cycles after `halted`.
- With `CHECKER_STUCK_PC_EN`, STUCK=64, `pc` held at 0x5 and `halted`=0 → code 4 after 64 cycles. Assert `reset_n`=0 mid-run → all outputs 0 asynchronously.

Source files
------------

// File: rtl/checker_pkg.sv
// checker_pkg: shared FSM state, fail-code and entry types for halt_result_checker
package checker_pkg;
    localparam int CHK_AW = 9;
    localparam int CHK_DW = 16;
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_CHK_PC, S_SCAN, S_CMP, S_PASS, S_FAIL} chk_state_t;
    typedef enum logic [2:0] {FC_NONE, FC_TIMEOUT, FC_BAD_PC, FC_DATA, FC_STUCK} chk_fail_t;
    // Entry layout at the default widths; the table stores the same fields at its parametrised widths.
    typedef struct packed {
        logic              valid;
        logic [CHK_AW-1:0] addr;
        logic [CHK_DW-1:0] data;
    } chk_entry_t;
endpackage

// File: rtl/checker_entry_table.sv
// checker_entry_table: NCHK-entry expected-value table with next-valid search
// Ports: clk, reset_n (async, active-low; clears valid bits)
//        we/widx/waddr/wdata/wvalid  single write port
//        from -> found/nxt           lowest valid index >= from
//        sel  -> addr/data           combinational read port
module checker_entry_table #(
    parameter int NCHK = 4,
    parameter int AW   = 9,
    parameter int DW   = 16,
    parameter int IW   = 2,
    parameter int CW   = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          wvalid,
    input  logic [CW-1:0] from,
    output logic          found,
    output logic [IW-1:0] nxt,
    input  logic [IW-1:0] sel,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data
);
    logic [NCHK-1:0] valid;
    logic [AW-1:0]   addr_q [NCHK];
    logic [DW-1:0]   data_q [NCHK];

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) valid <= '0;
        else if (we)  valid[widx] <= wvalid;

    always_ff @(posedge clk)
        if (we) begin
            addr_q[widx] <= waddr;
            data_q[widx] <= wdata;
        end

    // Walk downwards so the lowest qualifying index is the last one written.
    always_comb begin
        found = 1'b0;
        nxt   = '0;
        for (int j = NCHK - 1; j >= 0; j--)
            if (valid[j] && j >= int'(from)) begin
                found = 1'b1;
                nxt   = IW'(j);
            end
    end

    assign addr = addr_q[sel];
    assign data = data_q[sel];
endmodule

// File: rtl/halt_result_checker.sv
// halt_result_checker: waits for CPU halt, checks PC and a table of memory words, reports pass/fail
// Ports: clk, reset_n (async, active-low), start (arm pulse), halted, pc,
//        cfg_we/cfg_idx/cfg_addr/cfg_data/cfg_valid (table write, ignored while busy),
//        rd_en/rd_addr/rd_data (sync read port, data one cycle after rd_en),
//        busy, pass, fail, fail_code, fail_idx, fail_got (result, held until start or reset)
// Build option: define CHECKER_STUCK_PC_EN to add the stuck-PC watchdog (fail code 4).
module halt_result_checker
    import checker_pkg::*;
#(
    parameter int            AW      = 9,
    parameter int            DW      = 16,
    parameter int            NCHK    = 4,
    parameter int            TIMEOUT = 1024,
    parameter logic [AW-1:0] HALT_PC = AW'(9'hF),
    parameter int            STUCK   = 64,
    localparam int           IW      = (NCHK > 1) ? $clog2(NCHK) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          halted,
    input  logic [AW-1:0] pc,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    input  logic          cfg_valid,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          pass,
    output logic          fail,
    output logic [2:0]    fail_code,
    output logic [IW-1:0] fail_idx,
    output logic [DW-1:0] fail_got
);
    localparam int CW = IW + 1;
    // One width serves both the run counter and the stuck counter.
    localparam int TW = $clog2((TIMEOUT > STUCK) ? TIMEOUT : STUCK) + 1;

    chk_state_t    state;
    chk_fail_t     code;
    logic [TW-1:0] cnt;
    logic [CW-1:0] idx;
    logic          found, stuck;
    logic [IW-1:0] nxt;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_data;

    checker_entry_table #(.NCHK(NCHK), .AW(AW), .DW(DW), .IW(IW), .CW(CW)) u_table (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (cfg_we && !busy),
        .widx   (cfg_idx),
        .waddr  (cfg_addr),
        .wdata  (cfg_data),
        .wvalid (cfg_valid),
        .from   (idx),
        .found  (found),
        .nxt    (nxt),
        .sel    (state == S_SCAN ? nxt : idx[IW-1:0]),
        .addr   (t_addr),
        .data   (t_data)
    );

`ifdef CHECKER_STUCK_PC_EN
    logic [AW-1:0] prev_pc;
    logic [TW-1:0] scnt;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            prev_pc <= '0;
            scnt    <= '0;
        end else begin
            prev_pc <= pc;
            scnt    <= (state == S_RUN && pc == prev_pc) ? scnt + 1'b1 : '0;
        end
    assign stuck = pc == prev_pc && scnt == TW'(STUCK - 1);
`else
    assign stuck = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state    <= S_IDLE;
            code     <= FC_NONE;
            cnt      <= '0;
            idx      <= '0;
            fail_idx <= '0;
            fail_got <= '0;
        end else begin
            case (state)
                S_IDLE, S_PASS, S_FAIL:
                    if (start) begin
                        state    <= S_RUN;
                        code     <= FC_NONE;
                        cnt      <= '0;
                        idx      <= '0;
                        fail_idx <= '0;
                        fail_got <= '0;
                    end
                S_RUN:
                    if (halted) state <= S_CHK_PC;
                    else if (stuck) begin
                        state <= S_FAIL;
                        code  <= FC_STUCK;
                    end else if (cnt == TW'(TIMEOUT - 1)) begin
                        state <= S_FAIL;
                        code  <= FC_TIMEOUT;
                    end else cnt <= cnt + 1'b1;
                S_CHK_PC:
                    if (pc != HALT_PC) begin
                        state <= S_FAIL;
                        code  <= FC_BAD_PC;
                    end else begin
                        idx   <= '0;
                        state <= S_SCAN;
                    end
                S_SCAN:
                    if (found) begin
                        idx   <= CW'(nxt);
                        state <= S_CMP;
                    end else state <= S_PASS;
                S_CMP:
                    // Case inequality so X/Z read data is reported as a mismatch.
                    if (rd_data !== t_data) begin
                        state    <= S_FAIL;
                        code     <= FC_DATA;
                        fail_idx <= idx[IW-1:0];
                        fail_got <= rd_data;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_SCAN;
                    end
                default: state <= S_IDLE;
            endcase
        end

    assign busy      = state inside {S_RUN, S_CHK_PC, S_SCAN, S_CMP};
    assign rd_en     = state == S_SCAN && found;
    assign rd_addr   = rd_en ? t_addr : '0;
    assign pass      = state == S_PASS;
    assign fail      = state == S_FAIL;
    assign fail_code = code;
endmodule

// File: tb/tb_halt_result_checker.sv
// tb_halt_result_checker: table-driven directed bench for halt_result_checker
module tb_halt_result_checker;
    logic        clk = 0, reset_n = 0, start = 0, halted = 0, cfg_we = 0, cfg_valid = 0;
    logic [8:0]  pc = 0, cfg_addr = 0;
    logic [1:0]  cfg_idx = 0;
    logic [15:0] cfg_data = 0, rd_data = 0;
    logic        rd_en, busy, pass, fail;
    logic [8:0]  rd_addr;
    logic [2:0]  fail_code;
    logic [1:0]  fail_idx;
    logic [15:0] fail_got;
    int          n_tests = 0, n_fail = 0;
    logic [15:0] mem [512];
    logic [8:0]  rq [$];

    typedef struct {
        string       name;
        logic [8:0]  hpc;
        logic [3:0]  mask;
        logic [3:0]  wrong;
        logic        exp_pass;
        logic [2:0]  code;
        logic [1:0]  idx;
        logic [15:0] got;
        int          lat;
    } vec_t;
    vec_t v [7];

    halt_result_checker #(.TIMEOUT(200), .STUCK(64)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .halted(halted), .pc(pc),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
        .fail_idx(fail_idx), .fail_got(fail_got)
    );

    always #5 clk = ~clk;

    // Synchronous memory model plus a log of every read request.
    always @(posedge clk)
        if (rd_en) begin
            rq.push_back(rd_addr);
            rd_data <= mem[rd_addr];
        end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic write_entry(input int k, input logic vld, input logic bad);
        logic [8:0] a;
        a = 9'(20 + 3 * k);
        cfg_we = 1; cfg_idx = 2'(k); cfg_addr = a; cfg_data = mem[a] + 16'(bad); cfg_valid = vld;
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_rd_en"}, 32'(rd_en), 0);
        chk({nm, "_rd_addr"}, 32'(rd_addr), 0);
        chk({nm, "_pass"}, 32'(pass), 0);
        chk({nm, "_fail"}, 32'(fail), 0);
        chk({nm, "_code"}, 32'(fail_code), 0);
        chk({nm, "_idx"}, 32'(fail_idx), 0);
        chk({nm, "_got"}, 32'(fail_got), 0);
    endtask

    // Start a run, halt at pc after two RUN cycles, return edges counted after the halt sample.
    task automatic halt_run(input logic [8:0] hpc, output int lat);
        rq.delete();
        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        @(negedge clk);
        pc = hpc; halted = 1;
        lat = -1;
        do begin
            @(posedge clk); #1; lat++;
        end while (!(pass || fail) && lat < 40);
        @(negedge clk);
        halted = 0; pc = 0;
    endtask

    task automatic run_vec(input vec_t t);
        logic [8:0] ea [$];
        int lat, stop;
        for (int k = 0; k < 4; k++) write_entry(k, t.mask[k], t.wrong[k]);
        halt_run(t.hpc, lat);
        stop = (t.code == 3) ? int'(t.idx) : 3;
        for (int k = 0; k < 4; k++)
            if (t.code != 2 && t.mask[k] && k <= stop) ea.push_back(9'(20 + 3 * k));
        chk({t.name, "_pass"}, 32'(pass), 32'(t.exp_pass));
        chk({t.name, "_fail"}, 32'(fail), 32'(!t.exp_pass));
        chk({t.name, "_code"}, 32'(fail_code), 32'(t.code));
        chk({t.name, "_idx"}, 32'(fail_idx), 32'(t.idx));
        chk({t.name, "_got"}, 32'(fail_got), 32'(t.got));
        chk({t.name, "_lat"}, 32'(lat), 32'(t.lat));
        chk({t.name, "_busy"}, 32'(busy), 0);
        chk({t.name, "_nreads"}, 32'(rq.size()), 32'(ea.size()));
        for (int k = 0; k < ea.size() && k < rq.size(); k++)
            chk({t.name, "_raddr"}, 32'(rq[k]), 32'(ea[k]));
    endtask

    initial begin
        int n, lat;
        for (int i = 0; i < 512; i++) mem[i] = 16'(i);
        mem[20] = 16'd850; mem[23] = 16'd1000; mem[26] = 16'hBEEF; mem[29] = 16'd0;
        v[0] = '{"fig2_pass", 9'hF, 4'b0001, 4'b0000, 1'b1, 3'd0, 2'd0, 16'd0,   4};
        v[1] = '{"fig2_bad",  9'hF, 4'b0001, 4'b0001, 1'b0, 3'd3, 2'd0, 16'd850, 3};
        v[2] = '{"bad_pc",    9'hE, 4'b0001, 4'b0000, 1'b0, 3'd2, 2'd0, 16'd0,   1};
        v[3] = '{"sparse",    9'hF, 4'b0101, 4'b0000, 1'b1, 3'd0, 2'd0, 16'd0,   6};
        v[4] = '{"none",      9'hF, 4'b0000, 4'b0000, 1'b1, 3'd0, 2'd0, 16'd0,   2};
        v[5] = '{"last",      9'hF, 4'b1000, 4'b1000, 1'b0, 3'd3, 2'd3, 16'd0,   3};
        v[6] = '{"mid",       9'hF, 4'b1111, 4'b0100, 1'b0, 3'd3, 2'd2, 16'hBEEF, 7};

        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        reset_n = 1;
        @(negedge clk);

        foreach (v[i]) run_vec(v[i]);

        // Asynchronous reset while holding a failure result.
        #2 reset_n = 0;
        #1 check_zero("rst_in_fail");
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        // start and table writes while busy are ignored.
        write_entry(0, 1'b1, 1'b0);
        rq.delete();
        start = 1;
        @(negedge clk);
        start = 0;
        cfg_we = 1; cfg_idx = 0; cfg_addr = 9'd20; cfg_data = 16'd1; cfg_valid = 1;
        @(negedge clk);
        cfg_we = 0; start = 1;
        @(negedge clk);
        start = 0; pc = 9'hF; halted = 1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(pass || fail) && n < 40);
        @(negedge clk);
        halted = 0;
        chk("busy_ign_pass", 32'(pass), 1);
        chk("busy_ign_nreads", 32'(rq.size()), 1);

        // Watchdog timeout with pc moving every cycle.
        rq.delete();
        start = 1; n = 0;
        do begin @(posedge clk); #1; n++; start = 0; pc = pc + 1'b1; end while (!fail && n < 400);
        chk("timeout_cycles", 32'(n), 201);
        chk("timeout_code", 32'(fail_code), 1);
        chk("timeout_nreads", 32'(rq.size()), 0);
        @(negedge clk);

`ifdef CHECKER_STUCK_PC_EN
        pc = 9'h5; start = 1; n = 0;
        do begin @(posedge clk); #1; n++; start = 0; end while (!fail && n < 400);
        chk("stuck_cycles", 32'(n), 65);
        chk("stuck_code", 32'(fail_code), 4);
        @(negedge clk);
        pc = 0;
`endif

        // Reset in the middle of the table scan, then the table must be empty.
        for (int k = 0; k < 4; k++) write_entry(k, 1'b1, 1'b0);
        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        pc = 9'hF; halted = 1;
        n = 0;
        while (!rd_en && n < 20) begin @(negedge clk); n++; end
        chk("mid_scan_rd_en", 32'(rd_en), 1);
        #2 reset_n = 0;
        #1 check_zero("rst_mid_scan");
        @(negedge clk);
        halted = 0; reset_n = 1;
        @(negedge clk);
        halt_run(9'hF, lat);
        chk("post_rst_pass", 32'(pass), 1);
        chk("post_rst_nreads", 32'(rq.size()), 0);
        chk("post_rst_lat", 32'(lat), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
